ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single RAM port (ramaddr/ramstore/ramREN/ramWEN, ramload/ramstate) among NREQ cache requesters.
- Default NREQ=4: core0 icache, core0 dcache, core1 icache, core1 dcache.
- Uses round-robin arbitration with one outstanding RAM transaction at a time.
- Sits between the caches and the RAM interface, in place of direct cache-to-RAM wiring in the multicore top.

Parameters:
- NREQ, 4, number of requesters (2..8); index i is requester i.
- AW, 32, address/data word width.

Ports:
- CLK  input  1  system clock
- nRST  input  1  reset: one clock; reset is synchronous and active-low
- req_ren  input  NREQ  per-requester read request
- req_wen  input  NREQ  per-requester write request
- req_addr  input  NREQ x AW  per-requester word address
- req_store  input  NREQ x AW  per-requester write data
- req_wait  output  NREQ  1 = transaction not complete this cycle
- req_load  output  AW  read data, valid for the requester whose req_wait drops
- ramaddr  output  AW  RAM address
- ramstore  output  AW  RAM write data
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramload  input  AW  RAM read data
- ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (nRST low at a CLK edge):
  - state=IDLE, grant=0, ptr=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - req_wait = req_ren|req_wen (combinational).
  - req_load=0.
- A requester is active when req_ren[i]|req_wen[i]. If both are set, the requester is treated as a write (ramWEN=1, ramREN=0).
- IDLE:
  - Scan active requesters starting at ptr, wrapping modulo NREQ. The first hit is registered as grant; state goes to XFER.
  - RAM strobes stay 0 in IDLE, so grant-to-strobe latency is 1 cycle.
  - With no active requester, stay in IDLE.
- XFER:
  - ramaddr/ramstore/ramREN/ramWEN are driven combinationally from requester grant.
  - FREE or BUSY: hold.
  - ACCESS: req_wait[grant]=0 that cycle and req_load=ramload. Next state is IDLE; ptr = (grant+1) mod NREQ.
  - ERROR: treated as BUSY (hold and retry). req_wait[grant] stays 1.
- Non-granted active requesters see req_wait=1 at all times. Inactive requesters see req_wait=0.
- Minimum transaction is 2 cycles (IDLE, XFER with ACCESS), so back-to-back grants are spaced at least 2 cycles apart.
- Abort: if the granted requester deasserts both strobes during XFER:
  - RAM strobes drop that same cycle.
  - Next state is IDLE; ptr = grant+1.
  - No completion is signalled.
- Address change mid-XFER is forwarded as-is. Requesters must hold address/data until req_wait drops.
- Fairness: any continuously active requester is granted within NREQ transactions.
- Synchronous reset during XFER aborts the transaction: strobes are 0 the following cycle, state=IDLE, ptr=0.

Optional Feature:
- Macro: ARB_DPRIO_EN.
- Defined: in IDLE, active odd-index (dcache) requesters are considered first, in round-robin order from ptr. Even-index requesters are granted only when no odd requester is active.
- Undefined: pure round-robin over all requesters, as above.
- Starvation of icache under DPRIO is permitted and documented.

Decomposition:
- Shared package (existing cpu types package): ramstate_t enum (FREE, BUSY, ACCESS, ERROR), word_t, arb_state_t enum (IDLE, XFER).
- Sub-module rr_pick: combinational rotate-priority encoder with inputs req vector and ptr, outputs valid and index. Reused for the DPRIO masked pass.

Test Plan:
1. Reset with req_ren=4'b1111 -> ramREN=0 and req_wait=4'b1111 during reset. After release: grant=0 and ramaddr=req_addr[0] on the 2nd cycle.
2. All four requesters read; RAM returns ACCESS after 2 BUSY cycles -> completion order 0,1,2,3,0. req_load matches ramload each time. Exactly one req_wait bit low per completion.
3. req_ren[1]=req_wen[1]=1, addr=0x100, store=0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF. req_wait[1] drops on ACCESS.
4. ramstate ERROR for 3 cycles, then ACCESS -> grant held, strobes held, single completion with no advance until ACCESS.
5. Requester 2 granted, drops req_ren mid-XFER -> strobes 0 the same cycle. Next grant goes to requester 3 if it is active.
6. With ARB_DPRIO_EN defined, requesters 0 and 1 active and ptr=0 -> requester 1 granted first. Without the macro, requester 0 is granted first.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared RAM/arbiter types and constants for ram_arbiter.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef logic [31:0] word_t;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;
  localparam logic [7:0] ODD_MASK = 8'hAA;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// ram_arbiter_rr_pick: rotate-priority encoder, first set bit at or after i_ptr (wrapping).
module ram_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);
  int j;
  always_comb begin
    o_valid = |i_req;
    o_idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N;
      if (i_req[j]) o_idx = IW'(j);
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one RAM port among NREQ caches; ARB_DPRIO_EN favours odd (dcache) requesters.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][AW-1:0]  req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [AW-1:0]            req_load,
  output logic [AW-1:0]            ramaddr,
  output logic [AW-1:0]            ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic [AW-1:0]            ramload,
  input  logic [1:0]               ramstate
);
  localparam int IW = $clog2(NREQ);
  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_grant, r_ptr, w_grant_nxt, w_ptr_nxt, w_ptr_inc;
  logic [IW-1:0] w_all_idx, w_pick_idx;
  logic [NREQ-1:0] w_act;
  logic          w_all_v, w_pick_v, w_g_act, w_done;
  assign w_act = req_ren | req_wen;
  assign w_g_act = w_act[r_grant];
  assign w_ptr_inc = (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
  ram_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_all (
    .i_req(w_act), .i_ptr(r_ptr), .o_valid(w_all_v), .o_idx(w_all_idx)
  );
`ifdef ARB_DPRIO_EN
  logic          w_odd_v;
  logic [IW-1:0] w_odd_idx;
  ram_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_odd (
    .i_req(w_act & ODD_MASK[NREQ-1:0]), .i_ptr(r_ptr), .o_valid(w_odd_v), .o_idx(w_odd_idx)
  );
  assign w_pick_v   = w_all_v;
  assign w_pick_idx = w_odd_v ? w_odd_idx : w_all_idx;
`else
  assign w_pick_v   = w_all_v;
  assign w_pick_idx = w_all_idx;
`endif
  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    req_wait = w_act;
    req_load = '0;
    w_done = 1'b0;
    if (r_state == XFER && w_g_act) begin
      ramaddr = req_addr[r_grant];
      ramstore = req_store[r_grant];
      ramWEN = req_wen[r_grant];
      ramREN = req_ren[r_grant] & ~req_wen[r_grant];
      if (ramstate == ACCESS) begin
        req_wait[r_grant] = 1'b0;
        req_load = ramload;
        w_done = 1'b1;
      end
    end
  end
  // A dropped request (abort) and a completion both release the port and advance ptr.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt = r_ptr;
    if (r_state == IDLE && w_pick_v) begin
      w_state_nxt = XFER;
      w_grant_nxt = w_pick_idx;
    end else if (r_state == XFER && (w_done || !w_g_act)) begin
      w_state_nxt = IDLE;
      w_ptr_nxt = w_ptr_inc;
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter.
module tb_ram_arbiter;
  logic              CLK = 1'b0;
  logic              nRST;
  logic [3:0]        req_ren, req_wen, req_wait;
  logic [3:0][31:0]  req_addr, req_store;
  logic [31:0]       req_load, ramaddr, ramstore, ramload;
  logic              ramREN, ramWEN;
  logic [1:0]        ramstate;
  int n_tests = 0;
  int n_fail = 0;
  ram_arbiter #(.NREQ(4), .AW(32)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_wait(req_wait), .req_load(req_load),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramload(ramload), .ramstate(ramstate)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [31:0] a(input int i);
    return 32'h1000 + 32'(i * 16);
  endfunction
  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};
    int first;
    nRST = 1'b0;
    req_ren = 4'b1111;
    req_wen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = a(i);
      req_store[i] = 32'h5000 + 32'(i);
    end
    ramload = '0;
    ramstate = 2'd0;
    tick();
    tick();
    check("rst_ren", ramREN, 0);
    check("rst_wait", req_wait, 4'b1111);
    check("rst_addr", ramaddr, 0);
    check("rst_load", req_load, 0);
    nRST = 1'b1;
    #1;
    check("idle_ren", ramREN, 0);
    tick();
    check("first_addr", ramaddr, a(0));
    check("first_ren", ramREN, 1);
    for (int n = 0; n < 5; n++) begin
      ramstate = 2'd1;
      #1;
      check($sformatf("rr%0d_addr", n), ramaddr, a(ord[n]));
      check($sformatf("rr%0d_ren", n), ramREN, 1);
      check($sformatf("rr%0d_busy_wait", n), req_wait, 4'b1111);
      tick();
      tick();
      check($sformatf("rr%0d_hold", n), ramaddr, a(ord[n]));
      ramstate = 2'd2;
      ramload = 32'hA0 + 32'(n);
      #1;
      check($sformatf("rr%0d_wait", n), req_wait, 4'b1111 & ~(4'b0001 << ord[n]));
      check($sformatf("rr%0d_load", n), req_load, 32'hA0 + 32'(n));
      tick();
      ramstate = 2'd0;
      if (n == 4) req_ren = 4'b0000;
      #1;
      check($sformatf("rr%0d_gap", n), ramREN, 0);
      tick();
    end
    check("quiet_ren", ramREN, 0);
    req_ren = 4'b0010;
    req_wen = 4'b0010;
    req_addr[1] = 32'h100;
    req_store[1] = 32'hDEADBEEF;
    tick();
    check("wr_wen", ramWEN, 1);
    check("wr_ren", ramREN, 0);
    check("wr_addr", ramaddr, 32'h100);
    check("wr_store", ramstore, 32'hDEADBEEF);
    check("wr_wait_busy", req_wait, 4'b0010);
    ramstate = 2'd2;
    #1;
    check("wr_wait_done", req_wait, 4'b0000);
    tick();
    req_ren = 4'b0000;
    req_wen = 4'b0000;
    req_addr[1] = a(1);
    ramstate = 2'd0;
    tick();
    req_ren = 4'b1000;
    tick();
    ramstate = 2'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("err%0d_addr", c), ramaddr, a(3));
      check($sformatf("err%0d_ren", c), ramREN, 1);
      check($sformatf("err%0d_wait", c), req_wait, 4'b1000);
      tick();
    end
    ramstate = 2'd2;
    ramload = 32'h12345678;
    #1;
    check("err_done_wait", req_wait, 4'b0000);
    check("err_done_load", req_load, 32'h12345678);
    tick();
    req_ren = 4'b0000;
    ramstate = 2'd1;
    tick();
    req_ren = 4'b0100;
    tick();
    req_ren = 4'b1100;
    #1;
    check("abort_pre_addr", ramaddr, a(2));
    req_ren = 4'b1000;
    #1;
    check("abort_ren", ramREN, 0);
    check("abort_wen", ramWEN, 0);
    check("abort_wait", req_wait, 4'b1000);
    tick();
    check("abort_idle", ramREN, 0);
    tick();
    check("abort_next_addr", ramaddr, a(3));
    check("abort_next_ren", ramREN, 1);
    nRST = 1'b0;
    tick();
    check("xrst_ren", ramREN, 0);
    nRST = 1'b1;
    req_ren = 4'b0011;
    #1;
    check("xrst_idle_ren", ramREN, 0);
    check("xrst_wait", req_wait, 4'b0011);
    tick();
`ifdef ARB_DPRIO_EN
    first = 1;
`else
    first = 0;
`endif
    check("prio_addr", ramaddr, a(first));
    check("prio_ren", ramREN, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
